mac_seq: RTL
============

MAC_SEQ -- requirements
Module: mac_seq

Interface
REQ-001 Parameter ADDR_WIDTH, 10, width of both operand-memory read addresses.
REQ-002 Parameter CNT_WIDTH, 6, width of tap_count (max 63 products per run).
REQ-003 Clock: one clock, `clock`; reset: asynchronous, active-low, `resetn`.
REQ-004 clock  input  1  sole clock, rising edge.
REQ-005 resetn  input  1  asynchronous active-low reset.
REQ-006 start  input  1  run request, sampled only in IDLE.
REQ-007 tap_count  input  CNT_WIDTH  number of products to accumulate, latched on start.
REQ-008 base_a / base_b  input  ADDR_WIDTH each  first read address per operand memory, latched on start.
REQ-009 rd_en  output  1  read strobe to both operand memories.
REQ-010 addr_a / addr_b  output  ADDR_WIDTH each  read addresses, registered.
REQ-011 rdata_a / rdata_b  input  DATA_WIDTH each  memory data, valid exactly 1 cycle after rd_en.
REQ-012 mac_control  output  2  MAC op: 00 hold, 01 clear, 10 load product, 11 accumulate product.
REQ-013 mac_a / mac_b  output  DATA_WIDTH each  MAC operands, registered, aligned with mac_control.
REQ-014 acc_in  input  DATA_WIDTH  MAC accumulator output, registered inside the MAC.
REQ-015 busy  output  1  high from the cycle after start is accepted until done.
REQ-016 done  output  1  one-cycle pulse; result_out valid from this cycle.
REQ-017 result_out  output  DATA_WIDTH  captured final sum, held until the next accepted start.

Function
REQ-018 FSM states IDLE, FETCH, DRAIN, CAPTURE, DONE; IDLE->FETCH on start with tap_count>0.
REQ-019 FETCH: rd_en high for exactly N=tap_count consecutive cycles (1..N after accept); addresses base+0..base+N-1.
REQ-020 Address increment wraps modulo 2^ADDR_WIDTH; no error flagged.
REQ-021 rdata registered into mac_a/mac_b in cycles 3..N+2; mac_control=10 for the first product, 11 for the rest.
REQ-022 FETCH->DRAIN after issuing the last read; DRAIN lasts until the last product is presented (cycle N+2).
REQ-023 CAPTURE (cycle N+3): mac_control=00, result_out<=acc_in at end of cycle.
REQ-024 DONE (cycle N+4): done=1, busy=0, then IDLE; total latency start-accept to done = N+4 cycles.
REQ-025 tap_count=0: mac_control=01 in cycle 1, result_out<=0, done in cycle 2, no reads.
REQ-026 mac_control=00 in every cycle not listed above; start ignored while busy or in the done cycle.
REQ-027 mac_a/mac_b hold last values when mac_control=00.

Reset
REQ-028 resetn low, asynchronous: state IDLE; rd_en, busy, done 0; addr_a, addr_b, mac_a, mac_b, result_out 0; mac_control 00.
REQ-029 Reset mid-run abandons the run without a done pulse; first start after release behaves as from power-up.

Configuration
REQ-030 Macro MAC_SEQ_ABORT_EN: when defined, adds input abort (1 bit).
REQ-031 With MAC_SEQ_ABORT_EN: abort high in any state but IDLE -> next cycle mac_control=01, rd_en=0, no done, back to IDLE; result_out unchanged.
REQ-032 Without MAC_SEQ_ABORT_EN: no abort port; runs always complete.

Structure
REQ-033 DATA_WIDTH and the four mac_control encodings live in the shared defines file; FSM state codes stay local.
REQ-034 One sub-module, mac_seq_addr_gen: two wrapping address counters plus remaining-count counter.

Verification
REQ-035 tap_count=4, base_a=0, base_b=0x100, a={1,2,3,4}, b={5,6,7,8}, real MAC -> result_out=70, done at cycle 8, control 10,11,11,11.
REQ-036 tap_count=0 -> control 01 in cycle 1, done at cycle 2, result_out=0, rd_en never high.
REQ-037 base_a=0x3FE, tap_count=3 -> addr_a 0x3FE,0x3FF,0x000.
REQ-038 start pulsed every cycle during a tap_count=5 run -> exactly one run, one done pulse at cycle 9.
REQ-039 resetn low at cycle 3 of a tap_count=8 run -> all outputs 0 immediately, no done; next run of tap_count=2 correct.
REQ-040 With MAC_SEQ_ABORT_EN, abort at cycle 4 of tap_count=10 -> control 01 next cycle, no done, prior result_out kept.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared definitions for the MAC sequencer: datapath width, MAC control
// encodings and the operand pair payload.
package mac_seq_pkg;

  localparam int unsigned DATA_WIDTH = 16;
  localparam int unsigned CTRL_WIDTH = 2;

  // Operation requested from the external MAC each cycle
  typedef enum logic [CTRL_WIDTH-1:0] {
    MAC_HOLD  = 2'b00,
    MAC_CLEAR = 2'b01,
    MAC_LOAD  = 2'b10,
    MAC_ACC   = 2'b11
  } mac_ctrl_e;

  // Operand pair presented to the MAC together with mac_control
  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
  } mac_operands_t;

endpackage : mac_seq_pkg

// File: rtl/mac_seq_addr_gen.sv
// Read address generator: two wrapping operand address counters and a
// remaining-read counter that flags the last read of a run.
module mac_seq_addr_gen #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  load,
  input  logic                  step,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
  input  logic [CNT_WIDTH-1:0]  count,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  last_c
);

  logic [CNT_WIDTH-1:0] remaining;

  // Load bases on accept, then advance both addresses once per issued read
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      addr_a    <= '0;
      addr_b    <= '0;
      remaining <= '0;
    end else if (load) begin
      addr_a    <= base_a;
      addr_b    <= base_b;
      remaining <= count - CNT_WIDTH'(1);
    end else if (step) begin
      addr_a    <= addr_a + ADDR_WIDTH'(1);
      addr_b    <= addr_b + ADDR_WIDTH'(1);
      remaining <= remaining - CNT_WIDTH'(1);
    end
  end

  // The read currently on the bus is the last one of the run
  assign last_c = (remaining == '0);

endmodule : mac_seq_addr_gen

// File: rtl/mac_seq.sv
// MAC sequencer: streams tap_count operand pairs from two memories into an
// external MAC and captures the final accumulator value.
// Optional feature: define MAC_SEQ_ABORT_EN to add the abort input.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  tap_count,
  input  logic [ADDR_WIDTH-1:0] base_a,
  input  logic [ADDR_WIDTH-1:0] base_b,
`ifdef MAC_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] addr_a,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] rdata_a,
  input  logic [DATA_WIDTH-1:0] rdata_b,
  output logic [CTRL_WIDTH-1:0] mac_control,
  output logic [DATA_WIDTH-1:0] mac_a,
  output logic [DATA_WIDTH-1:0] mac_b,
  input  logic [DATA_WIDTH-1:0] acc_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e        state;
  mac_operands_t ops;
  logic          rdata_vld;
  logic          first_prod;
  logic          zero_run;
  logic          abort_req;
  logic          gen_load;
  logic          gen_step;
  logic          last_c;

`ifdef MAC_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Address counters start on a non-empty accepted run and step per read
  assign gen_load = (state == S_IDLE) && start && (tap_count != '0);
  assign gen_step = (state == S_FETCH) && !last_c && !abort_req;

  mac_seq_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_addr_gen (
    .clock  (clock),
    .resetn (resetn),
    .load   (gen_load),
    .step   (gen_step),
    .base_a (base_a),
    .base_b (base_b),
    .count  (tap_count),
    .addr_a (addr_a),
    .addr_b (addr_b),
    .last_c (last_c)
  );

  assign mac_a = ops.a;
  assign mac_b = ops.b;

  // Run sequencing and all registered outputs; rdata_vld tracks the memory
  // read latency so products are presented the cycle after data returns
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= S_IDLE;
      rd_en       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      mac_control <= MAC_HOLD;
      ops         <= '0;
      result_out  <= '0;
      rdata_vld   <= 1'b0;
      first_prod  <= 1'b0;
      zero_run    <= 1'b0;
    end else begin
      mac_control <= MAC_HOLD;
      done        <= 1'b0;
      rdata_vld   <= rd_en;

      if (rdata_vld) begin
        ops         <= '{a: rdata_a, b: rdata_b};
        mac_control <= first_prod ? MAC_LOAD : MAC_ACC;
        first_prod  <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (tap_count != '0) begin
              state      <= S_FETCH;
              rd_en      <= 1'b1;
              first_prod <= 1'b1;
              zero_run   <= 1'b0;
            end else begin
              state       <= S_CAPTURE;
              mac_control <= MAC_CLEAR;
              zero_run    <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          if (last_c) begin
            rd_en <= 1'b0;
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!rdata_vld) begin
            state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          result_out <= zero_run ? '0 : acc_in;
          busy       <= 1'b0;
          done       <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      // Abort drops the run, clears the MAC and leaves result_out alone
      if (abort_req && (state != S_IDLE)) begin
        state       <= S_IDLE;
        rd_en       <= 1'b0;
        busy        <= 1'b0;
        done        <= 1'b0;
        rdata_vld   <= 1'b0;
        first_prod  <= 1'b0;
        mac_control <= MAC_CLEAR;
      end
    end
  end

endmodule : mac_seq
